// File: rtl/serial_subtractor_n.sv
// serial_subtractor_n
//   Bit-serial unsigned subtractor. A start request in IDLE captures the
//   operands and borrow-in. The core then processes one bit per clock, LSB
//   first, through a one-bit full subtractor for BITS clocks. It publishes
//   the difference and borrow-out and pulses done for one cycle.
//
// Parameters
//   BITS   operand/result width (2..32)
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   start  begin one subtraction (only looked at in IDLE)
//   a      unsigned minuend, captured on accepted start
//   b      unsigned subtrahend, captured on accepted start
//   bin    borrow-in, captured on accepted start
//   busy   high while the subtraction is running
//   done   one-cycle pulse when diff/bout hold a new result
//   diff   registered difference (a - b - bin) mod 2^BITS
//   bout   registered borrow-out (a < b + bin)
module serial_subtractor_n #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] diff,
  output logic            bout
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [BITS-1:0] a_sh;
  logic [BITS-1:0] b_sh;
  logic [BITS-2:0] d_sh;
  logic            br;
  logic [CW-1:0]   cnt;

  logic            d_bit;
  logic            br_next;
  logic            last_bit;
  logic [BITS-1:0] d_cat;

  // One-bit full subtractor on the current LSBs plus the running borrow.
  // The partial difference is kept one bit short. The bit being produced
  // right now is concatenated on top. On the final bit this gives the
  // complete result in one shot. Partial values never reach diff.
  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_bit = (cnt == LAST);
    d_cat    = {d_bit, d_sh};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE always falls back to IDLE. A start held high
  // is therefore accepted on the following edge, one operation every BITS+2.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_bit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: capture on accept, shift one bit per RUN clock. On the last
  // bit, commit diff/bout together with the final borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            d_sh <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          d_sh <= d_cat[BITS-1:1];
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            diff <= d_cat;
            bout <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
